// File: rtl/distribute_1_n_wn_pkg.sv
// ============================================================================
//  Module      : distribute_1_n_wn_pkg
//  Description : Shared definitions for the 1-to-N registered stream
//                distributor: zero-fill constant, lane-slice helper macro
//                for the flattened lane data bus and a parameter legality
//                check used at elaboration time.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

// Bit range of lane k inside a flattened bus of w-bit lanes.
`ifndef DIST_LANE
`define DIST_LANE(k, w) ((k)*(w)) +: (w)
`endif

package distribute_1_n_wn_pkg;

    // Widest data word supported; the zero-fill constant is sliced down to
    // the actual word width wherever an empty lane must drive zeros.
    localparam int c_max_dwidth = 1024;
    localparam logic [c_max_dwidth-1:0] c_zero_fill = '0;

    // Legal configurations: 2..16 lanes, every lane addressable by the
    // destination index, word width within the zero-fill constant.
    function automatic bit dist_params_ok(input int nout, input int swidth,
                                          input int dwidth);
        return (nout >= 2) && (nout <= 16) && (swidth >= 1) &&
               (nout <= (1 << swidth)) &&
               (dwidth >= 1) && (dwidth <= c_max_dwidth);
    endfunction

endpackage

`default_nettype wire

// File: rtl/distribute_1_n_wn_lane.sv
// ============================================================================
//  Module      : dist_lane_slot
//  Description : One-entry output register for a single distributor lane.
//                Load has priority over drain so that a simultaneous
//                drain+load keeps the slot full with the new word.
//                Data is cleared whenever the slot empties, so o_data is
//                zero whenever o_full is low.
//  Ports       : clk, reset     - clock, synchronous active-high reset
//                i_load, i_data - load strobe and word from the decoder
//                i_ready        - consumer accepts this lane this cycle
//                o_full, o_data - registered lane valid / lane data
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dist_lane_slot
    import distribute_1_n_wn_pkg::*;
#(
    parameter int dwidth = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_load,
    input  logic [dwidth-1:0] i_data,
    input  logic              i_ready,
    output logic              o_full,
    output logic [dwidth-1:0] o_data
);

    logic              r_full;
    logic [dwidth-1:0] r_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_full <= 1'b0;
            r_data <= c_zero_fill[dwidth-1:0];
        end else if (i_load) begin
            // Covers both load-into-empty and drain-and-replace.
            r_full <= 1'b1;
            r_data <= i_data;
        end else if (r_full && i_ready) begin
            r_full <= 1'b0;
            r_data <= c_zero_fill[dwidth-1:0];
        end
    end

    assign o_full = r_full;
    assign o_data = r_data;

endmodule

`default_nettype wire

// File: rtl/distribute_1_n_wn.sv
// ============================================================================
//  Module      : distribute_1_n_wn
//  Description : Registered 1-to-N stream distributor. One word per
//                handshake is steered by sel0 into one of nout one-entry
//                lane registers. Out-of-range indices are accepted, dropped
//                and flagged with a one-cycle err0 pulse.
//  Ports       : clk, reset          - clock, synchronous active-high reset
//                i0, sel0, valid0    - input word, destination, valid
//                ready0              - combinational accept (sel0/o_ready)
//                o_data, o_valid     - flattened lane data, lane valids
//                o_ready             - per-lane consumer ready
//                err0                - out-of-range index dropped
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module distribute_1_n_wn
    import distribute_1_n_wn_pkg::*;
#(
    parameter int dwidth = 32,
    parameter int nout   = 4,
    parameter int swidth = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [dwidth-1:0]      i0,
    input  logic [swidth-1:0]      sel0,
    input  logic                   valid0,
    output logic                   ready0,
    output logic [nout*dwidth-1:0] o_data,
    output logic [nout-1:0]        o_valid,
    input  logic [nout-1:0]        o_ready,
    output logic                   err0
);

    // Number of codes sel0 can express; lane status vectors are padded to
    // this size so that indexing with any sel0 value stays in range.
    localparam int c_nsel = 1 << swidth;

    generate
        if (!dist_params_ok(nout, swidth, dwidth)) begin : g_param_err
            $error("distribute_1_n_wn: illegal parameters nout=%0d swidth=%0d dwidth=%0d",
                   nout, swidth, dwidth);
        end
    endgenerate

    logic [nout-1:0]   w_full;
    logic [nout-1:0]   w_load;
    logic [c_nsel-1:0] w_full_pad;
    logic [c_nsel-1:0] w_ordy_pad;
    logic              w_in_range;
    logic              w_accept;
    logic              r_err;

    assign w_in_range = (32'(sel0) < 32'(nout));
    assign w_full_pad = c_nsel'(w_full);
    assign w_ordy_pad = c_nsel'(o_ready);

    // Out-of-range words are always taken (and dropped); an in-range word
    // is taken when its lane is empty or is being drained this cycle.
    assign ready0   = ~w_in_range | ~w_full_pad[sel0] | w_ordy_pad[sel0];
    assign w_accept = valid0 & ready0 & w_in_range;

    generate
        for (genvar k = 0; k < nout; k++) begin : g_lane
            assign w_load[k] = w_accept & (sel0 == swidth'(k));

            dist_lane_slot #(
                .dwidth (dwidth)
            ) u_slot (
                .clk     (clk),
                .reset   (reset),
                .i_load  (w_load[k]),
                .i_data  (i0),
                .i_ready (o_ready[k]),
                .o_full  (w_full[k]),
                .o_data  (o_data[`DIST_LANE(k, dwidth)])
            );
        end
    endgenerate

    assign o_valid = w_full;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_err <= 1'b0;
        end else begin
            r_err <= valid0 & ~w_in_range;
        end
    end

    assign err0 = r_err;

endmodule

`default_nettype wire
